instruction_mem_controller: RTL
===============================

// Module: instruction_mem_controller
// PURPOSE
//  Responder side of the instruction-memory read handshake driven by each warp's fetcher.
//  Accepts NUM_CONSUMERS independent valid/address requests and arbitrates them round-robin.
//  Forwards one request at a time to the single external program-memory read channel.
//  Returns the fetched instruction to the requester with a one-cycle ready pulse.
//  Sits between the per-warp fetchers and program memory.
// PARAMETERS
//  NUM_CONSUMERS  4  number of fetchers served (>=1); index width CW = max(1,$clog2(NUM_CONSUMERS))
// PORTS
//  clk                    in   1                        clock; all state updates on posedge
//  reset                  in   1                        synchronous, active-high
//  consumer_read_valid    in   [NUM_CONSUMERS]          request held high until its ready pulse is seen
//  consumer_read_address  in   [NUM_CONSUMERS] x instruction_memory_address_t   requested PC per consumer
//  consumer_read_ready    out  [NUM_CONSUMERS]          one-cycle pulse: data for that consumer valid
//  consumer_read_data     out  [NUM_CONSUMERS] x instruction_t                  fetched instruction per consumer
//  mem_read_valid         out  1                        request to program memory
//  mem_read_address       out  instruction_memory_address_t                     address of forwarded request
//  mem_read_ready         in   1                        memory response strobe, data valid this cycle
//  mem_read_data          in   instruction_t            instruction returned by memory
// BEHAVIOUR
//  Reset (sync, active-high; overrides everything, including mid-transaction):
//   - state=CTRL_IDLE, rr_ptr=0, sel=0.
//   - mem_read_valid=0, mem_read_address=0, consumer_read_ready=0, all consumer_read_data=0.
//   - An in-flight memory request is abandoned; mem_read_valid is low in the first cycle after reset.
//  All outputs registered. FSM states: CTRL_IDLE -> CTRL_WAIT_MEM -> CTRL_RESPOND -> CTRL_IDLE.
//  CTRL_IDLE:
//   - Grant the first i with consumer_read_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_CONSUMERS.
//   - On grant: sel<=i, mem_read_valid<=1, mem_read_address<=consumer_read_address[i], go to WAIT_MEM.
//   - No valid request: stay in IDLE, outputs unchanged.
//  CTRL_WAIT_MEM:
//   - mem_read_valid and mem_read_address held stable until mem_read_ready=1.
//   - On mem_read_ready: mem_read_valid<=0, consumer_read_data[sel]<=mem_read_data,
//     consumer_read_ready[sel]<=1, go to RESPOND.
//   - No timeout; waits indefinitely.
//  CTRL_RESPOND:
//   - consumer_read_ready<=0 (pulse exactly one cycle), rr_ptr<=(sel+1) mod NUM_CONSUMERS, go to IDLE.
//   - The fetcher drops valid at the edge it samples ready, so in the following IDLE cycle
//     that consumer's valid is already low; no double service.
//  Data hold: consumer_read_data[i] holds its value until the next response to consumer i;
//   other consumers' data is never disturbed.
//  Ignored inputs:
//   - mem_read_ready outside WAIT_MEM is ignored.
//   - Address changes on a non-granted consumer are ignored.
//   - The granted consumer's address is captured at grant; later changes are ignored.
//  Latency (memory ready in same cycle as mem_read_valid):
//   - Consumer valid first high in cycle t -> mem_read_valid high in t+1 -> consumer_read_ready high in t+2.
//   - Controller back in IDLE at t+3, with at most one transaction outstanding.
//  Fairness: a continuously requesting consumer waits at most NUM_CONSUMERS-1 other transactions.
//  Wrap: rr_ptr wraps NUM_CONSUMERS-1 -> 0; NUM_CONSUMERS=1 always grants index 0.
// TESTING
//  1 single req: valid[0]=1, addr=0x05, memory ready same cycle with data 0xABCD ->
//    mem_read_address=0x05 at t+1; ready[0] pulse at t+2 only; data[0]=0xABCD.
//  2 all four valid at once, addrs 0x10..0x13 -> served in order 0,1,2,3;
//    each ready a single-cycle pulse; data lands only in the matching slot.
//  3 rr_ptr=3 after serving 2, then valid[0] and valid[3] both high -> 3 granted first, then 0 (wrap).
//  4 memory stalls 5 cycles -> mem_read_valid/address stable for all 5;
//    no consumer ready until mem_read_ready.
//  5 reset in WAIT_MEM -> next cycle mem_read_valid=0, all ready=0, data=0;
//    a later request is granted from index 0.
//  6 stray mem_read_ready while IDLE with data 0xFFFF -> no ready pulse, no data slot changed.

Source files
------------

// File: rtl/instruction_mem_controller.sv
// Round-robin arbiter forwarding fetcher reads to one program-memory port; grant +1 cycle, response +1 after mem ready.
// Backpressure: one transaction in flight, requests held until their ready pulse, memory stalls waited out indefinitely.
module instruction_mem_controller #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 16,
    localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1
) (
    input  logic                                     i_clk,
    input  logic                                     i_reset,
    input  logic [NUM_CONSUMERS-1:0]                 i_consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_WIDTH-1:0] i_consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                 o_consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0] o_consumer_read_data,
    output logic                                     o_mem_read_valid,
    output logic [ADDR_WIDTH-1:0]                    o_mem_read_address,
    input  logic                                     i_mem_read_ready,
    input  logic [DATA_WIDTH-1:0]                    i_mem_read_data
);

    typedef enum logic [1:0] {
        CTRL_IDLE     = 2'd0,
        CTRL_WAIT_MEM = 2'd1,
        CTRL_RESPOND  = 2'd2
    } ctrl_state_t;

    ctrl_state_t                             r_state;
    logic [CW-1:0]                           r_rr_ptr;
    logic [CW-1:0]                           r_sel;
    logic                                    r_mem_vld;
    logic [ADDR_WIDTH-1:0]                   r_mem_addr;
    logic [NUM_CONSUMERS-1:0]                r_rdy;
    logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0] r_data;

    logic          w_grant_vld;
    logic [CW-1:0] w_grant_idx;
    logic [CW:0]   w_sum;
    logic [CW-1:0] w_cand;
    logic [CW-1:0] w_next_ptr;

    // Scan from the far end back toward rr_ptr so the candidate closest to rr_ptr wins.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_sum       = '0;
        w_cand      = '0;
        for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
            w_sum  = {1'b0, r_rr_ptr} + (CW+1)'(k);
            w_cand = (w_sum >= (CW+1)'(NUM_CONSUMERS)) ? CW'(w_sum - (CW+1)'(NUM_CONSUMERS))
                                                       : CW'(w_sum);
            if (i_consumer_read_valid[w_cand]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    assign w_next_ptr = (r_sel == CW'(NUM_CONSUMERS - 1)) ? '0 : r_sel + CW'(1);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= CTRL_IDLE;
            r_rr_ptr   <= '0;
            r_sel      <= '0;
            r_mem_vld  <= 1'b0;
            r_mem_addr <= '0;
            r_rdy      <= '0;
            r_data     <= '0;
        end else begin
            case (r_state)
                CTRL_IDLE: begin
                    if (w_grant_vld) begin
                        r_sel      <= w_grant_idx;
                        r_mem_vld  <= 1'b1;
                        r_mem_addr <= i_consumer_read_address[w_grant_idx];
                        r_state    <= CTRL_WAIT_MEM;
                    end
                end
                CTRL_WAIT_MEM: begin
                    if (i_mem_read_ready) begin
                        r_mem_vld     <= 1'b0;
                        r_data[r_sel] <= i_mem_read_data;
                        r_rdy[r_sel]  <= 1'b1;
                        r_state       <= CTRL_RESPOND;
                    end
                end
                CTRL_RESPOND: begin
                    r_rdy    <= '0;
                    r_rr_ptr <= w_next_ptr;
                    r_state  <= CTRL_IDLE;
                end
                default: r_state <= CTRL_IDLE;
            endcase
        end
    end

    assign o_consumer_read_ready = r_rdy;
    assign o_consumer_read_data  = r_data;
    assign o_mem_read_valid      = r_mem_vld;
    assign o_mem_read_address    = r_mem_addr;

endmodule
